button_debounce: RTL and testbench
==================================

# button_debounce

Upstream conditioning stage for the board push-buttons: takes one raw, active-low, asynchronous button pin and produces a synchronised, debounced, active-high level plus single-cycle press/release strobes. One instance per button (BUT1, BUT2) sits between the pad and the LED/decision logic, which then consumes clean levels instead of raw pins. The block has no dependence on the consumer's logic.

## Interface
- DEBOUNCE_CYCLES, default 1000000 — input must be stable this many clock cycles before a change is accepted (10 ms at 100 MHz); legal range 1 .. 2^CNT_W-1
- CNT_W, default 20 — debounce counter width
- LONG_CYCLES, default 50000000 — long-press threshold in cycles (used only with BUTTON_DEBOUNCE_LONGPRESS_EN); must be < 2^LONG_W
- LONG_W, default 26 — long-press counter width
- CLK  in  1  system clock; single clock domain
- RST  in  1  synchronous, active-high reset
- BUT_N  in  1  raw button pin, active-low, asynchronous to CLK
- BUT_LEVEL  out  1  debounced state, 1 = pressed
- BUT_PRESS  out  1  one-cycle strobe on accepted press
- BUT_RELEASE  out  1  one-cycle strobe on accepted release
- BUT_LONG  out  1  one-cycle strobe on long press (constant 0 when feature compiled out)

## Operation
- Input path: BUT_N through a 2-flop synchroniser, inverted to s (1 = pressed). Synchroniser flops reset to the released value (BUT_N = 1).
- FSM states: REL (stable released), WAIT_P (candidate press), PRS (stable pressed), WAIT_R (candidate release).
- REL: s=1 -> WAIT_P, cnt <= 0.
- WAIT_P: s=0 -> REL, cnt <= 0, no strobe. s=1 and cnt == DEBOUNCE_CYCLES-1 -> PRS, BUT_PRESS pulses. Else cnt <= cnt+1.
- PRS: s=0 -> WAIT_R, cnt <= 0.
- WAIT_R: s=1 -> PRS, cnt <= 0, no strobe. s=0 and cnt == DEBOUNCE_CYCLES-1 -> REL, BUT_RELEASE pulses. Else cnt <= cnt+1.
- BUT_LEVEL = 1 in PRS and WAIT_R, 0 in REL and WAIT_P; registered, changes on the same edge as the corresponding strobe.
- All outputs registered; no combinational path from BUT_N to any output.
- Counter never wraps: compare terminates counting before 2^CNT_W-1.
- BUT_PRESS and BUT_RELEASE never assert in the same cycle; at most one strobe per FSM transition.

## Timing
- Reset: while RST=1 on an edge, FSM -> REL, cnt=0, sync flops released, BUT_LEVEL=0, BUT_PRESS=0, BUT_RELEASE=0, BUT_LONG=0.
- Press latency: with BUT_N held low, BUT_LEVEL and BUT_PRESS assert after the (DEBOUNCE_CYCLES+3)th rising edge counting the first edge that samples BUT_N low. Release latency identical.
- Any opposite-level sample during WAIT_P/WAIT_R restarts the qualification; a bounce train is accepted only after its final DEBOUNCE_CYCLES-long stable run.
- Reset mid-qualification or while pressed: no strobe emitted; after RST deasserts with button held, press is reported after DEBOUNCE_CYCLES+3 edges as a fresh press.
- Strobes are exactly one cycle wide.

## Configuration
- BUTTON_DEBOUNCE_LONGPRESS_EN defined: a long counter clears on entry to PRS and increments each cycle in PRS; when it reaches LONG_CYCLES-1, BUT_LONG pulses one cycle; it then saturates so BUT_LONG fires once per press. WAIT_R returning to PRS does not clear the long counter; entry to REL does.
- Not defined: long counter absent, BUT_LONG tied to 0; port list unchanged.

## Structure
- Shared header button_defs.vh: FSM state encodings (REL, WAIT_P, PRS, WAIT_R, 2 bits) and default DEBOUNCE_CYCLES/LONG_CYCLES constants.
- One sub-module: sync_2ff (2-flop synchroniser, parameterised reset value), reused by other pad inputs.

## Test plan
- DEBOUNCE_CYCLES=4, RST held 3 cycles -> all outputs 0; release RST, BUT_N=1 for 20 cycles -> outputs stay 0.
- DEBOUNCE_CYCLES=4, BUT_N low and held -> BUT_LEVEL=1 and BUT_PRESS=1 after edge 7, BUT_PRESS low at edge 8; BUT_N high -> BUT_RELEASE one cycle after edge 7, BUT_LEVEL=0.
- DEBOUNCE_CYCLES=4, BUT_N bounces low 2 / high 1 / low 3 / high 2 cycles -> no strobe, BUT_LEVEL stays 0.
- DEBOUNCE_CYCLES=4, press accepted, assert RST for 1 cycle while held -> outputs 0, no BUT_RELEASE; new BUT_PRESS after 7 edges post-reset.
- Macro defined, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, hold 40 cycles -> exactly one BUT_LONG, 10 cycles after BUT_PRESS; macro undefined -> BUT_LONG always 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared FSM state encodings and default timing constants for button_debounce.
// Latency: n/a (constants only).
// Backpressure: n/a.
package button_debounce_pkg;

  // Debounce FSM state encodings (2 bits).
  localparam logic [1:0] ST_REL    = 2'd0;  // stable released
  localparam logic [1:0] ST_WAIT_P = 2'd1;  // candidate press being qualified
  localparam logic [1:0] ST_PRS    = 2'd2;  // stable pressed
  localparam logic [1:0] ST_WAIT_R = 2'd3;  // candidate release being qualified

  // Defaults: 10 ms debounce and 500 ms long press at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs, reset to a chosen idle value.
// Latency: 2 CLK edges from pad to q.
// Backpressure: none; q follows d continuously.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages take the idle value in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces one active-low button pin into a level plus press/release/long strobes.
// Latency: DEBOUNCE_CYCLES+3 edges from first low sample to BUT_LEVEL/BUT_PRESS.
// Backpressure: none; strobes are single-cycle. Long press needs BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int LONG_W          = 26
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUT_N,
  output logic BUT_LEVEL,
  output logic BUT_PRESS,
  output logic BUT_RELEASE,
  output logic BUT_LONG
);

  // Reject parameter sets whose terminal counts cannot be represented.
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) >= (longint'(1) << LONG_W)) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES out of range for LONG_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             but_n_sync;
  logic             s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             press_accept;
  logic             release_accept;

  // Pad idles high (released), so the synchroniser resets to 1.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (BUT_N),
    .q   (but_n_sync)
  );

  assign s = ~but_n_sync;

  // Qualification completes on the sample where the counter hits its terminal value.
  assign press_accept   = (state == ST_WAIT_P) && s  && (cnt == CNT_LAST);
  assign release_accept = (state == ST_WAIT_R) && !s && (cnt == CNT_LAST);

  // Debounce FSM; level and strobes are registered alongside the state change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_REL;
      cnt         <= '0;
      BUT_LEVEL   <= 1'b0;
      BUT_PRESS   <= 1'b0;
      BUT_RELEASE <= 1'b0;
    end else begin
      BUT_PRESS   <= 1'b0;
      BUT_RELEASE <= 1'b0;
      case (state)
        ST_REL: begin
          if (s) begin
            state <= ST_WAIT_P;
            cnt   <= '0;
          end
        end
        ST_WAIT_P: begin
          if (!s) begin
            state <= ST_REL;
            cnt   <= '0;
          end else if (press_accept) begin
            state     <= ST_PRS;
            cnt       <= '0;
            BUT_LEVEL <= 1'b1;
            BUT_PRESS <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PRS: begin
          if (!s) begin
            state <= ST_WAIT_R;
            cnt   <= '0;
          end
        end
        ST_WAIT_R: begin
          if (s) begin
            state <= ST_PRS;
            cnt   <= '0;
          end else if (release_accept) begin
            state       <= ST_REL;
            cnt         <= '0;
            BUT_LEVEL   <= 1'b0;
            BUT_RELEASE <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_REL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt;

  // Long-press timer: counts PRS cycles, fires once, then parks at LONG_SAT until
  // a fresh press or a confirmed release clears it (bounces via WAIT_R keep it).
  always_ff @(posedge CLK) begin
    if (RST) begin
      long_cnt <= '0;
      BUT_LONG <= 1'b0;
    end else begin
      BUT_LONG <= 1'b0;
      if (press_accept || release_accept) begin
        long_cnt <= '0;
      end else if (state == ST_PRS) begin
        if (long_cnt == LONG_LAST) begin
          BUT_LONG <= 1'b1;
          long_cnt <= LONG_SAT;
        end else if (long_cnt < LONG_LAST) begin
          long_cnt <= long_cnt + LONG_W'(1);
        end
      end
    end
  end
`else
  // Long-press feature compiled out: output held low.
  always_ff @(posedge CLK) begin
    BUT_LONG <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios then random bounce trains.
// Reference model: run-length of disagreeing samples after a 2-sample pad delay.
// Outputs sampled 1 time unit after each rising edge.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BUT_N = 1'b1;
  logic BUT_LEVEL, BUT_PRESS, BUT_RELEASE, BUT_LONG;

  always #5 CLK = ~CLK;

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20),
    .LONG_CYCLES     (L),
    .LONG_W          (26)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BUT_N       (BUT_N),
    .BUT_LEVEL   (BUT_LEVEL),
    .BUT_PRESS   (BUT_PRESS),
    .BUT_RELEASE (BUT_RELEASE),
    .BUT_LONG    (BUT_LONG)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit m_p1, m_p2;          // raw pin as seen 1 and 2 edges ago
  bit m_level;
  int m_run;               // consecutive samples disagreeing with m_level
  int m_lc;                // stable-pressed cycles since last press
  bit m_fired;
  bit m_press, m_rel, m_long;

  int edge_no = 0;
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int press_edge = -1, rel_edge = -1, long_edge = -1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  // A level change is accepted once D+1 consecutive post-synchroniser samples
  // disagree with the current level; any agreeing sample restarts the run.
  task automatic model_edge(input bit rst, input bit raw);
    bit s;
    bit stable_pressed;
    m_press = 0; m_rel = 0; m_long = 0;
    if (rst) begin
      m_p1 = 1; m_p2 = 1; m_level = 0; m_run = 0; m_lc = 0; m_fired = 0;
      return;
    end
    s = !m_p2;
    m_p2 = m_p1;
    m_p1 = raw;
    stable_pressed = m_level && (m_run == 0);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    if (stable_pressed) begin
      if (!m_fired && m_lc == L - 1) begin
        m_long = 1;
        m_fired = 1;
      end
      m_lc++;
    end
`else
    if (stable_pressed) m_lc++;
`endif
    if (s != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = s;
        m_run = 0;
        m_lc = 0;
        m_fired = 0;
        if (s) m_press = 1; else m_rel = 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input bit rst, input bit raw);
    RST = rst;
    BUT_N = raw;
    @(posedge CLK);
    edge_no++;
    model_edge(rst, raw);
    if (m_press) begin press_cnt++; press_edge = edge_no; end
    if (m_rel)   begin rel_cnt++;   rel_edge   = edge_no; end
    if (m_long)  begin long_cnt++;  long_edge  = edge_no; end
    #1;
    chk("level",   BUT_LEVEL,   m_level);
    chk("press",   BUT_PRESS,   m_press);
    chk("release", BUT_RELEASE, m_rel);
    chk("long",    BUT_LONG,    m_long);
    chk("press_release_exclusive", BUT_PRESS & BUT_RELEASE, 1'b0);
  endtask

  initial begin
    int base;
    int p0, r0, l0;
    bit raw;
    int len;

    // Reset held 3 cycles, then released idle for 20 cycles.
    for (int i = 0; i < 3; i++) step(1, 1);
    for (int i = 0; i < 20; i++) step(0, 1);
    chk_int("idle_press_count", press_cnt, 0);

    // Clean press: strobe on the 7th edge that sees the pin low.
    base = edge_no;
    for (int i = 0; i < 10; i++) step(0, 0);
    chk_int("press_latency", press_edge, base + D + 3);
    base = edge_no;
    for (int i = 0; i < 10; i++) step(0, 1);
    chk_int("release_latency", rel_edge, base + D + 3);

    // Bounce train too short to qualify.
    p0 = press_cnt; r0 = rel_cnt;
    for (int i = 0; i < 2; i++) step(0, 0);
    step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 0);
    for (int i = 0; i < 2; i++) step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 1);
    chk_int("bounce_no_press", press_cnt, p0);
    chk_int("bounce_no_release", rel_cnt, r0);

    // Reset while held: no release strobe, fresh press afterwards.
    for (int i = 0; i < 10; i++) step(0, 0);
    r0 = rel_cnt;
    step(1, 0);
    base = edge_no;
    for (int i = 0; i < 12; i++) step(0, 0);
    chk_int("reset_no_release", rel_cnt, r0);
    chk_int("fresh_press_latency", press_edge, base + D + 3);
    for (int i = 0; i < 10; i++) step(0, 1);

    // Long hold: exactly one long strobe, L cycles after the press.
    l0 = long_cnt;
    for (int i = 0; i < 40; i++) step(0, 0);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    chk_int("long_once", long_cnt - l0, 1);
    chk_int("long_delay", long_edge - press_edge, L);
`else
    chk_int("long_absent", long_cnt - l0, 0);
`endif
    for (int i = 0; i < 10; i++) step(0, 1);

    // Random bounce trains with occasional reset.
    for (int seg = 0; seg < 400; seg++) begin
      raw = 1'($urandom_range(0, 1));
      len = (($urandom % 4) == 0) ? int'($urandom_range(5, 16)) : int'($urandom_range(1, 6));
      if (($urandom % 40) == 0) step(1, raw);
      for (int i = 0; i < len; i++) step(0, raw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
